serial_negator: RTL and testbench

Parametrised, multi-channel successor to the single-bit serial two's-complementer. It accepts CH parallel bit-serial words, LSB first, each WIDTH bits long. For each word it applies a per-word mode: pass, negate, or absolute value. The result is re-emitted bit-serially, one word later, with an overflow flag. It sits between the serial data sources and the serial arithmetic datapath, and removes the external per-word reset strobe by counting bit positions internally.

---
 rtl/serial_negator_pkg.sv | 24 ++
 rtl/serial_neg_lane.sv | 68 ++++++
 rtl/serial_negator.sv | 78 +++++++
 tb/tb_serial_negator.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_negator_pkg.sv
// Shared mode encodings and helpers for the serial negator.
// Imported by serial_negator and serial_neg_lane.
package serial_negator_pkg;

  typedef enum logic [1:0] {
    MODE_PASS  = 2'd0,
    MODE_NEG   = 2'd1,
    MODE_ABS   = 2'd2,
    MODE_PASS3 = 2'd3
  } mode_e;

  // A word is negated for NEG always, for ABS only when negative.
  function automatic logic neg_needed(
    input mode_e m,
    input logic  msb
  );
    unique case (1'b1)
      (m == MODE_NEG): neg_needed = 1'b1;
      (m == MODE_ABS): neg_needed = msb;
      default:         neg_needed = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/serial_neg_lane.sv
// One lane: capture shift register, output shift register and the
// serial two's-complement decode. Ports: capture strobes, load/shift
// sequencing from the top, latched mode; out_bit/out_ovf per lane.
module serial_neg_lane
  import serial_negator_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic  t_clk,
  input  logic  r_n,
  input  logic  in_valid,
  input  logic  in_sof,
  input  logic  in_bit,
  input  logic  load,
  input  logic  active,
  input  mode_e mode_l,
  output logic  out_bit,
  output logic  out_ovf
);

  localparam logic [WIDTH-1:0] MIN_VAL =
    {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0] cap;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] word;
  logic             neg;
  logic             ovf;
  logic             seen_one;
  logic             neg_w;

  // The bit arriving now is the MSB when a load happens.
  assign word  = {in_bit, cap[WIDTH-1:1]};
  assign neg_w = neg_needed(mode_l, in_bit);

  always_ff @(posedge t_clk or negedge r_n) begin
    if (!r_n) begin
      cap <= '0;
    end else if (in_valid) begin
      // Resync drops whatever partial word was held.
      cap <= in_sof ? {in_bit, {(WIDTH-1){1'b0}}}
                    : word;
    end
  end

  always_ff @(posedge t_clk or negedge r_n) begin
    if (!r_n) begin
      sr       <= '0;
      neg      <= 1'b0;
      ovf      <= 1'b0;
      seen_one <= 1'b0;
    end else if (load) begin
      // Load beats the final shift of the previous word.
      sr       <= word;
      neg      <= neg_w;
      ovf      <= neg_w & (word == MIN_VAL);
      seen_one <= 1'b0;
    end else if (active) begin
      sr       <= sr >> 1;
      seen_one <= seen_one | sr[0];
    end
  end

  // Invert every bit after the first 1 when negating.
  assign out_bit = active & ((neg & seen_one) ? ~sr[0] : sr[0]);
  assign out_ovf = active & ovf;

endmodule

// File: rtl/serial_negator.sv
// Multi-lane bit-serial pass/negate/abs with internal word framing.
// Ports: t_clk, r_n, in_valid/in_sof/in_bit/mode in; out_* out.
module serial_negator
  import serial_negator_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CH    = 2
) (
  input  logic          t_clk,
  input  logic          r_n,
  input  logic          in_valid,
  input  logic          in_sof,
  input  logic [CH-1:0] in_bit,
  input  logic [1:0]    mode,
  output logic          out_valid,
  output logic          out_sof,
  output logic [CH-1:0] out_bit,
  output logic [CH-1:0] out_ovf
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] pos;
  logic [CW-1:0] ocnt;
  logic          load;
  mode_e         mode_l;

  // in_sof relabels the current bit as position 0.
  assign pos  = in_sof ? '0 : cnt;
  assign load = in_valid & (pos == LAST);

  always_ff @(posedge t_clk or negedge r_n) begin
    if (!r_n) begin
      cnt    <= '0;
      mode_l <= MODE_PASS;
    end else if (in_valid) begin
      cnt <= (pos == LAST) ? '0 : pos + CW'(1);
      if (pos == '0) begin
        mode_l <= mode_e'(mode);
      end
    end
  end

  always_ff @(posedge t_clk or negedge r_n) begin
    if (!r_n) begin
      out_valid <= 1'b0;
      ocnt      <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      ocnt      <= '0;
    end else if (out_valid) begin
      out_valid <= (ocnt != LAST);
      ocnt      <= (ocnt == LAST) ? '0 : ocnt + CW'(1);
    end
  end

  assign out_sof = out_valid & (ocnt == '0);

  for (genvar i = 0; i < CH; i++) begin : g_lane
    serial_neg_lane #(
      .WIDTH(WIDTH)
    ) u_lane (
      .t_clk   (t_clk),
      .r_n     (r_n),
      .in_valid(in_valid),
      .in_sof  (in_sof),
      .in_bit  (in_bit[i]),
      .load    (load),
      .active  (out_valid),
      .mode_l  (mode_l),
      .out_bit (out_bit[i]),
      .out_ovf (out_ovf[i])
    );
  end

endmodule

// File: tb/tb_serial_negator.sv
// Self-checking bench for serial_negator, WIDTH=8, CH=2.
module tb_serial_negator;

  localparam int W  = 8;
  localparam int CH = 2;
  localparam int NV = 8;

  logic          t_clk = 1'b0;
  logic          r_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_sof = 1'b0;
  logic [CH-1:0] in_bit = '0;
  logic [1:0]    mode = 2'd0;
  logic          out_valid;
  logic          out_sof;
  logic [CH-1:0] out_bit;
  logic [CH-1:0] out_ovf;

  always #5 t_clk = ~t_clk;

  serial_negator #(.WIDTH(W), .CH(CH)) dut (
    .t_clk    (t_clk),
    .r_n      (r_n),
    .in_valid (in_valid),
    .in_sof   (in_sof),
    .in_bit   (in_bit),
    .mode     (mode),
    .out_valid(out_valid),
    .out_sof  (out_sof),
    .out_bit  (out_bit),
    .out_ovf  (out_ovf)
  );

  typedef struct {
    logic [1:0] m;
    logic [7:0] a, b, ea, eb;
    logic       oa, ob;
  } vec_t;

  typedef struct {
    logic [7:0] a, b;
    logic       oa, ob;
  } exp_t;

  vec_t tbl[NV];
  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   run_len = 0;
  int   last_run = 0;
  int   sof_cnt = 0;
  bit   mid_reset = 0;

  task automatic chk(string name, int act, int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  // Reference: negate means value 256-x; the most negative byte
  // maps to itself and is flagged.
  function automatic exp_t model(logic [1:0] m,
                                 logic [7:0] a, logic [7:0] b);
    exp_t e;
    bit na = (m == 2'd1) || (m == 2'd2 && int'(a) >= 128);
    bit nb = (m == 2'd1) || (m == 2'd2 && int'(b) >= 128);
    e.a  = na ? 8'((256 - int'(a)) % 256) : a;
    e.b  = nb ? 8'((256 - int'(b)) % 256) : b;
    e.oa = na && (a == 8'h80);
    e.ob = nb && (b == 8'h80);
    return e;
  endfunction

  task automatic monitor();
    int k = 0;
    logic [7:0] ga = '0, gb = '0;
    exp_t cur = '{default: '0};
    forever begin
      @(negedge t_clk);
      if (out_valid) begin
        run_len++;
        if (out_sof) begin
          sof_cnt++;
          if (k != 0) chk("sof_mid_word", k, 0);
          k = 0;
          if (exp_q.size() == 0) begin
            chk("unexpected_word", 1, 0);
            cur = '{default: '0};
          end else begin
            cur = exp_q.pop_front();
          end
        end else if (k == 0) begin
          chk("missing_sof", 0, 1);
        end
        ga[k[2:0]] = out_bit[0];
        gb[k[2:0]] = out_bit[1];
        chk("ovf0", int'(out_ovf[0]), int'(cur.oa));
        chk("ovf1", int'(out_ovf[1]), int'(cur.ob));
        k++;
        if (k == W) begin
          chk("data0", int'(ga), int'(cur.a));
          chk("data1", int'(gb), int'(cur.b));
          k = 0;
        end
      end else begin
        if (run_len != 0) last_run = run_len;
        run_len = 0;
        if (k != 0 && !mid_reset) chk("truncated", k, 0);
        k = 0;
      end
    end
  endtask

  task automatic drive(bit v, bit s, logic [1:0] b,
                       logic [1:0] m);
    @(negedge t_clk);
    in_valid = v;
    in_sof   = s;
    in_bit   = b;
    mode     = m;
  endtask

  task automatic idle(int n);
    repeat (n) drive(1'b0, 1'($urandom), 2'($urandom),
                     2'($urandom));
  endtask

  task automatic send(logic [1:0] m, logic [7:0] a,
                      logic [7:0] b, bit gaps);
    for (int i = 0; i < W; i++) begin
      if (gaps)
        while ($urandom_range(0, 3) == 0) idle(1);
      drive(1'b1, i == 0, {b[i], a[i]},
            (i == 0) ? m : 2'($urandom));
    end
  endtask

  task automatic partial(int n);
    for (int i = 0; i < n; i++)
      drive(1'b1, i == 0, 2'($urandom), 2'($urandom));
  endtask

  task automatic push(logic [1:0] m, logic [7:0] a,
                      logic [7:0] b);
    exp_q.push_back(model(m, a, b));
  endtask

  task automatic wait_idle();
    int t = 0;
    drive(1'b0, 1'b0, 2'b00, 2'b00);
    while ((exp_q.size() != 0 || out_valid) && t < 300) begin
      @(negedge t_clk);
      t++;
    end
    chk("drain", exp_q.size(), 0);
    idle(2);
  endtask

  task automatic check_quiet(string tag);
    chk({tag, "_valid"}, int'(out_valid), 0);
    chk({tag, "_sof"},   int'(out_sof), 0);
    chk({tag, "_bit"},   int'(out_bit), 0);
    chk({tag, "_ovf"},   int'(out_ovf), 0);
  endtask

  function automatic logic [7:0] rnd_byte();
    logic [7:0] v = 8'($urandom);
    case ($urandom_range(0, 7))
      0: v = 8'h80;
      1: v = 8'h7F;
      2: v = 8'h00;
      3: v = 8'hFF;
      default: ;
    endcase
    return v;
  endfunction

  initial begin
    fork
      monitor();
    join_none

    tbl[0] = '{2'd1, 8'h06, 8'h5A, 8'hFA, 8'hA6, 1'b0, 1'b0};
    tbl[1] = '{2'd0, 8'h06, 8'h5A, 8'h06, 8'h5A, 1'b0, 1'b0};
    tbl[2] = '{2'd2, 8'hFA, 8'h06, 8'h06, 8'h06, 1'b0, 1'b0};
    tbl[3] = '{2'd1, 8'h00, 8'h80, 8'h00, 8'h80, 1'b0, 1'b1};
    tbl[4] = '{2'd2, 8'h7F, 8'h80, 8'h7F, 8'h80, 1'b0, 1'b1};
    tbl[5] = '{2'd3, 8'h80, 8'hFF, 8'h80, 8'hFF, 1'b0, 1'b0};
    tbl[6] = '{2'd1, 8'h01, 8'hFF, 8'hFF, 8'h01, 1'b0, 1'b0};
    tbl[7] = '{2'd2, 8'h81, 8'h00, 8'h7F, 8'h00, 1'b0, 1'b0};

    repeat (3) @(negedge t_clk);
    check_quiet("in_reset");
    r_n = 1'b1;
    idle(4);
    check_quiet("idle");

    // Fixed vectors, back to back with in_valid held high.
    sof_cnt = 0;
    foreach (tbl[i]) begin
      exp_q.push_back('{tbl[i].ea, tbl[i].eb,
                        tbl[i].oa, tbl[i].ob});
      send(tbl[i].m, tbl[i].a, tbl[i].b, 1'b0);
    end
    wait_idle();
    chk("run_len", last_run, W * NV);
    chk("sof_cnt", sof_cnt, NV);

    // Resync mid-word and on the final bit position.
    push(2'd1, 8'h06, 8'h5A);
    send(2'd1, 8'h06, 8'h5A, 1'b1);
    partial(3);
    push(2'd2, 8'hFA, 8'h80);
    send(2'd2, 8'hFA, 8'h80, 1'b1);
    partial(7);
    push(2'd1, 8'h80, 8'h7F);
    send(2'd1, 8'h80, 8'h7F, 1'b0);
    wait_idle();

    // Random words, gaps and resyncs.
    for (int n = 0; n < 40; n++) begin
      logic [1:0] m = 2'($urandom);
      logic [7:0] a = rnd_byte();
      logic [7:0] b = rnd_byte();
      if ($urandom_range(0, 4) == 0)
        partial($urandom_range(1, W - 1));
      if ($urandom_range(0, 3) == 0)
        idle($urandom_range(1, 3));
      push(m, a, b);
      send(m, a, b, 1'b1);
    end
    wait_idle();

    // Reset pulse while an output word is in flight.
    begin
      int t = 0;
      push(2'd1, 8'h80, 8'h01);
      send(2'd1, 8'h80, 8'h01, 1'b0);
      drive(1'b0, 1'b0, 2'b00, 2'b00);
      while (!out_valid && t < 30) begin
        @(negedge t_clk);
        t++;
      end
      chk("out_started", int'(out_valid), 1);
      repeat (3) @(negedge t_clk);
      mid_reset = 1'b1;
      #2 r_n = 1'b0;
      #1 check_quiet("mid_reset");
      exp_q.delete();
      @(negedge t_clk);
      r_n = 1'b1;
      idle(3);
      mid_reset = 1'b0;
      check_quiet("post_reset");
    end

    push(2'd2, 8'hC3, 8'h3C);
    send(2'd2, 8'hC3, 8'h3C, 1'b1);
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
